// File: rtl/seven_seg_pkg.sv
// Shared constants, types and helpers for the multi-register 7-segment display driver.
package seven_seg_pkg;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} encoding for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {MANUAL, AUTO} state_e;

  // Register-select width; never narrower than one bit.
  function automatic int unsigned sel_width(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seven_segment_multi_display_if.sv
// Bus between the register file / controller and the display driver.
interface seven_segment_multi_display_if import seven_seg_pkg::*; #(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SEL_W      = sel_width(NUM_REGS)
) ();

  logic [NUM_REGS*DATA_W-1:0] reg_data;
  logic [SEL_W-1:0]           reg_select;
  logic                       mode_auto;
  logic                       blank_lz;
  logic                       hold;
  logic [NUM_DIGITS*7-1:0]    seg_out;
  logic [SEL_W-1:0]           active_index;
  logic                       index_strobe;

  modport master (
    output reg_data, reg_select, mode_auto, blank_lz, hold,
    input  seg_out, active_index, index_strobe
  );

  modport slave (
    input  reg_data, reg_select, mode_auto, blank_lz, hold,
    output seg_out, active_index, index_strobe
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode import seven_seg_pkg::*; (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seven_segment_multi_display.sv
// Multi-register hex display driver: manual or timed auto-rotation over NUM_REGS
// registers, snapshot of the selected register, registered active-low digit outputs.
module seven_segment_multi_display import seven_seg_pkg::*; #(
  parameter int unsigned NUM_REGS     = 4,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned SHOW_INDEX   = 1
) (
  input logic                          clk_clk,
  input logic                          reset_reset,
  seven_segment_multi_display_if.slave bus
);

  localparam int unsigned SEL_W = sel_width(NUM_REGS);
  localparam int unsigned ND    = DATA_W / 4;
  localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(NUM_REGS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        dwell_q, dwell_d;
  logic [SEL_W-1:0]        index_q, index_d;
  logic                    strobe_q, strobe_d;
  logic [DATA_W-1:0]       snap_q, snap_d;
  logic [NUM_DIGITS*7-1:0] seg_q, seg_d;

  logic                    sel_ok;
  logic [3:0]              idx_nib;
  logic [6:0]              idx_seg;
  logic [6:0]              dec_seg [ND];
  int                      msn;

  assign sel_ok  = 32'(bus.reg_select) < NUM_REGS;
  assign idx_nib = 4'(index_q);

  // Mode FSM, dwell counter and index selection.
  always_comb begin
    state_d = bus.mode_auto ? AUTO : MANUAL;
    dwell_d = dwell_q;
    index_d = index_q;
    case (state_q)
      MANUAL: begin
        // Counter sits at zero so rotation starts a full dwell after entering AUTO.
        dwell_d = '0;
        if (!bus.hold && sel_ok) index_d = bus.reg_select;
      end
      AUTO: begin
        if (!bus.hold) begin
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            index_d = (index_q == IDX_LAST) ? '0 : index_q + SEL_W'(1);
          end else begin
            dwell_d = dwell_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
    strobe_d = (index_d != index_q);
    snap_d   = bus.hold ? snap_q : bus.reg_data[index_q*DATA_W +: DATA_W];
  end

  // Per-digit hex decoders plus one for the index digit.
  for (genvar g = 0; g < ND; g++) begin : g_dec
    seg7_hex_decode u_dec (
      .hex (snap_q[g*4 +: 4]),
      .seg (dec_seg[g])
    );
  end

  seg7_hex_decode u_idx_dec (
    .hex (idx_nib),
    .seg (idx_seg)
  );

  // Locate the most significant non-zero nibble (0 when the snapshot is zero).
  always_comb begin
    msn = 0;
    for (int i = 0; i < ND; i++) begin
      if (snap_q[i*4 +: 4] != 4'h0) msn = i;
    end
  end

  // Assemble the digit image: data digits, optional blanking, optional index digit.
  always_comb begin
    seg_d = {NUM_DIGITS{SEG_BLANK}};
    for (int i = 0; i < ND; i++) begin
      seg_d[i*7 +: 7] = (bus.blank_lz && (i > msn)) ? SEG_BLANK : dec_seg[i];
    end
    if (SHOW_INDEX != 0) seg_d[(NUM_DIGITS-1)*7 +: 7] = idx_seg;
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q  <= MANUAL;
      dwell_q  <= '0;
      index_q  <= '0;
      strobe_q <= 1'b0;
      snap_q   <= '0;
      seg_q    <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      index_q  <= index_d;
      strobe_q <= strobe_d;
      snap_q   <= snap_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.seg_out      = seg_q;
  assign bus.active_index = index_q;
  assign bus.index_strobe = strobe_q;

endmodule

// File: tb/tb_seven_segment_multi_display.sv
// Scoreboard bench for seven_segment_multi_display (4-register and 3-register instances).
module tb_seven_segment_multi_display;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    string       tag;
    int          sig;
    logic [63:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  exp_t sb [$];

  seven_segment_multi_display_if #(.NUM_REGS(4), .DATA_W(16), .NUM_DIGITS(8)) bus4 ();
  seven_segment_multi_display_if #(.NUM_REGS(3), .DATA_W(16), .NUM_DIGITS(8)) bus3 ();

  seven_segment_multi_display #(
    .NUM_REGS(4), .DATA_W(16), .NUM_DIGITS(8), .DWELL_CYCLES(4), .SHOW_INDEX(1)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus4)
  );

  seven_segment_multi_display #(
    .NUM_REGS(3), .DATA_W(16), .NUM_DIGITS(8), .DWELL_CYCLES(4), .SHOW_INDEX(1)
  ) dut3 (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int sig, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  // Pop every pending expectation and compare with the DUT outputs now.
  task automatic drain();
    exp_t        e;
    logic [63:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sig)
        0:       act = 64'(bus4.seg_out);
        1:       act = 64'(bus4.active_index);
        2:       act = 64'(bus4.index_strobe);
        3:       act = 64'(bus3.seg_out);
        4:       act = 64'(bus3.active_index);
        default: act = 64'(bus3.index_strobe);
      endcase
      check_eq(e.tag, act, e.val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected 8-digit image for a 16-bit value plus an index digit on digit 7.
  function automatic logic [63:0] exp_seg(input logic [15:0] v, input logic [3:0] idx,
                                          input bit blz);
    logic [55:0] r;
    logic [3:0]  nib;
    int          top;
    r   = '1;
    top = 0;
    for (int i = 0; i < 4; i++) if (v[i*4 +: 4] != 4'h0) top = i;
    for (int i = 0; i < 4; i++) begin
      nib = v[i*4 +: 4];
      if (!blz || i <= top) r[i*7 +: 7] = HEX_TAB[nib];
    end
    r[49 +: 7] = HEX_TAB[idx];
    return 64'(r);
  endfunction

  int pulses;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    bus4.reg_data   = {16'h0070, 16'hBEEF, 16'h0005, 16'h1A3C};
    bus4.reg_select = '0;
    bus4.mode_auto  = 1'b0;
    bus4.blank_lz   = 1'b0;
    bus4.hold       = 1'b0;
    bus3.reg_data   = {16'hC0DE, 16'h0001, 16'h00F0};
    bus3.reg_select = '0;
    bus3.mode_auto  = 1'b0;
    bus3.blank_lz   = 1'b1;
    bus3.hold       = 1'b0;

    // Reset values.
    #2 rst = 1'b1;
    #1;
    push("rst_seg", 0, {8'h0, {8{7'h7F}}});
    push("rst_idx", 1, 64'd0);
    push("rst_stb", 2, 64'd0);
    drain();
    tick(2);
    rst = 1'b0;

    // 1: manual index 0, no blanking, two clocks to the display.
    tick(2);
    push("t1_seg", 0, exp_seg(16'h1A3C, 4'd0, 1'b0));
    drain();

    // 2: register 1 with leading-zero blanking.
    bus4.reg_select = 2'd1;
    bus4.blank_lz   = 1'b1;
    tick(1);
    push("t2_idx", 1, 64'd1);
    push("t2_stb", 2, 64'd1);
    drain();
    tick(1);
    push("t2_stb_off", 2, 64'd0);
    drain();
    tick(1);
    push("t2_seg5", 0, exp_seg(16'h0005, 4'd1, 1'b1));
    drain();
    bus4.reg_data[31:16] = 16'h0000;
    tick(2);
    push("t2_seg0", 0, exp_seg(16'h0000, 4'd1, 1'b1));
    drain();

    // 3: auto rotation from index 0, step every 4 clocks.
    bus4.reg_select = 2'd0;
    tick(3);
    push("t3_start", 1, 64'd0);
    drain();
    bus4.mode_auto = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 17; k++) begin
      tick(1);
      push("t3_idx", 1, 64'(((k - 1) / 4) % 4));
      push("t3_stb", 2, 64'((k > 1 && ((k - 1) % 4) == 0) ? 1 : 0));
      if (k > 1 && bus4.index_strobe) pulses++;
      drain();
    end
    check_eq("t3_pulses", 64'(pulses), 64'd4);

    // 4: hold mid-dwell (count 2) for 10 clocks while data changes.
    bus4.reg_data = {16'h0070, 16'hBEEF, 16'h0000, 16'h1A3C};
    tick(2);
    bus4.hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus4.reg_data = {$urandom, $urandom};
      tick(1);
      push("t4_seg", 0, exp_seg(16'h1A3C, 4'd0, 1'b1));
      push("t4_idx", 1, 64'd0);
      push("t4_stb", 2, 64'd0);
      drain();
    end
    bus4.hold     = 1'b0;
    bus4.reg_data = {16'h0070, 16'hBEEF, 16'h0000, 16'h1A3C};
    tick(1);
    push("t4_rel_idx", 1, 64'd0);
    drain();
    tick(1);
    push("t4_step_idx", 1, 64'd1);
    push("t4_step_stb", 2, 64'd1);
    drain();

    // 6: asynchronous reset mid-dwell, then restart from MANUAL.
    tick(2);
    #3 rst = 1'b1;
    #1;
    push("t6_seg", 0, {8'h0, {8{7'h7F}}});
    push("t6_idx", 1, 64'd0);
    push("t6_stb", 2, 64'd0);
    drain();
    tick(1);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      push("t6_restart", 1, 64'((k == 5) ? 1 : 0));
      drain();
    end
    bus4.mode_auto = 1'b0;

    // 5: three registers, out-of-range select holds the index.
    bus3.reg_select = 2'd2;
    tick(1);
    push("t5_idx2", 4, 64'd2);
    push("t5_stb2", 5, 64'd1);
    drain();
    tick(2);
    push("t5_seg2", 3, exp_seg(16'hC0DE, 4'd2, 1'b1));
    drain();
    bus3.reg_select = 2'd3;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      push("t5_oor_idx", 4, 64'd2);
      push("t5_oor_stb", 5, 64'd0);
      drain();
    end
    bus3.reg_select = 2'd0;
    tick(1);
    push("t5_idx0", 4, 64'd0);
    push("t5_stb0", 5, 64'd1);
    drain();
    tick(1);
    push("t5_stb0_off", 5, 64'd0);
    drain();
    tick(1);
    push("t5_seg0", 3, exp_seg(16'h00F0, 4'd0, 1'b1));
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
